// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator car scheduler: state encoding and
// default sizing of the shaft and its timing.
package elevator_pkg;

    localparam int N_FLOORS_DEF   = 4;
    localparam int FW_DEF         = $clog2(N_FLOORS_DEF);
    localparam int TRAVEL_CYC_DEF = 8;
    localparam int DOOR_CYC_DEF   = 6;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3,
        EMERG     = 3'd4
    } state_t;

endpackage

// File: rtl/elevator_scheduler_look_decider.sv
// LOOK direction decision: given the pending calls, the car position and the
// committed direction, say where the car should go next.
module look_decider
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FW       = FW_DEF
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FW-1:0]       current_floor,
    input  logic                dir_up,
    output logic                go_up,
    output logic                go_down,
    output logic                flip,
    output logic                any_ahead
);

    logic above;
    logic below;

    // Scan the pending set for calls strictly above / strictly below the car.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (i > int'(current_floor))) above = 1'b1;
            if (pending[i] && (i < int'(current_floor))) below = 1'b1;
        end
    end

    // Keep going while calls lie ahead; reverse only when everything is behind.
    assign any_ahead = dir_up ? above : below;
    assign flip      = !any_ahead && (dir_up ? below : above);
    assign go_up     = above && (dir_up || !below);
    assign go_down   = below && !go_up;

endmodule

// File: rtl/elevator_scheduler.sv
// Elevator car scheduler: latches floor calls, serves them in LOOK order,
// times floor-to-floor travel and door dwell, and drives the motor commands.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter  int N_FLOORS   = N_FLOORS_DEF,
    parameter  int TRAVEL_CYC = TRAVEL_CYC_DEF,
    parameter  int DOOR_CYC   = DOOR_CYC_DEF,
    localparam int FW         = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] floor_req,
    input  logic                emergency_stop,
    output logic                move_up,
    output logic                move_down,
    output logic                motor_stop,
    output logic                door_open,
    output logic [FW-1:0]       current_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                dir_up
);

    localparam int TW = $clog2(TRAVEL_CYC + 1);
    localparam int DW = $clog2(DOOR_CYC + 1);

    state_t              state_q, state_d, saved_q, saved_d, norm_next;
    logic [FW-1:0]       floor_q, floor_d, nf;
    logic [N_FLOORS-1:0] pending_q, pending_d, served_mask, cur_oh;
    logic                dir_up_q, dir_up_d;
    logic [TW-1:0]       trav_q, trav_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic                step_up, step_dn;
    logic                go_up, go_down, flip, any_ahead;

    look_decider #(
        .N_FLOORS (N_FLOORS),
        .FW       (FW)
    ) u_look (
        .pending       (pending_q),
        .current_floor (floor_q),
        .dir_up        (dir_up_q),
        .go_up         (go_up),
        .go_down       (go_down),
        .flip          (flip),
        .any_ahead     (any_ahead)
    );

    assign cur_oh = N_FLOORS'(1) << floor_q;

    // Next-state, counters and served-call mask. Emergency only redirects the
    // state into EMERG and remembers where to resume; the current cycle's
    // action still completes, and EMERG itself holds every counter.
    always_comb begin
        norm_next   = state_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        trav_d      = trav_q;
        dwell_d     = dwell_q;
        served_mask = '0;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        nf          = floor_q;
        case (state_q)
            IDLE: begin
                if (floor_req[floor_q] || pending_q[floor_q]) begin
                    norm_next   = DOOR_OPEN;
                    served_mask = cur_oh;
                end else if (go_up) begin
                    norm_next = MOVE_UP;
                    dir_up_d  = 1'b1;
                end else if (go_down) begin
                    norm_next = MOVE_DOWN;
                    dir_up_d  = 1'b0;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (trav_q == TW'(TRAVEL_CYC - 1)) begin
                    trav_d  = '0;
                    step_up = (state_q == MOVE_UP);
                    step_dn = (state_q == MOVE_DOWN);
                    nf      = step_up ? floor_q + 1'b1 : floor_q - 1'b1;
                    floor_d = nf;
                    if (pending_q[nf]) begin
                        norm_next   = DOOR_OPEN;
                        served_mask = N_FLOORS'(1) << nf;
                    end
                end else begin
                    trav_d = trav_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                // Calls for the open floor are absorbed and just extend dwell.
                served_mask = cur_oh;
                if (floor_req[floor_q]) begin
                    dwell_d = '0;
                end else if (dwell_q == DW'(DOOR_CYC - 1)) begin
                    dwell_d = '0;
                    if (any_ahead) begin
                        norm_next = dir_up_q ? MOVE_UP : MOVE_DOWN;
                    end else if (flip) begin
                        dir_up_d  = !dir_up_q;
                        norm_next = dir_up_q ? MOVE_DOWN : MOVE_UP;
                    end else begin
                        norm_next = IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            EMERG:   norm_next = saved_q;
            default: norm_next = IDLE;
        endcase

        state_d   = emergency_stop ? EMERG : norm_next;
        saved_d   = (emergency_stop && state_q != EMERG) ? norm_next : saved_q;
        pending_d = (pending_q | floor_req) & ~served_mask;
    end

    // State, position, direction, counters and pending-call register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            saved_q   <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
            trav_q    <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
            trav_q    <= trav_d;
            dwell_q   <= dwell_d;
        end
    end

    // Catch any attempt to step the car off either end of the shaft.
    always_comb begin
        if (reset) begin
            assert (!(step_up && floor_q == FW'(N_FLOORS - 1)));
            assert (!(step_dn && floor_q == '0));
        end
    end

    assign move_up       = (state_q == MOVE_UP);
    assign move_down     = (state_q == MOVE_DOWN);
    assign motor_stop    = !(move_up || move_down);
    assign door_open     = (state_q == DOOR_OPEN);
    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign dir_up        = dir_up_q;

endmodule
